seq_det_arbiter: RTL and testbench

SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

---
 rtl/seq_det_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_seq_det_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter.sv
// rtl/seq_det_arbiter.sv - round-robin arbiter sharing one sequence detector among NREQ symbol streams
//
// Grants one requester at a time. Each grant is framed by a one-cycle detector
// clear and a one-cycle drain, so symbols from different requesters never mix
// inside the detector. A grant ends on req_last, after BURST symbols, or after
// TMO consecutive idle cycles. Detector matches are credited to the requester
// that owned the matching symbol.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous reset, active HIGH (1 = reset)
//   req_valid    [NREQ]        per-requester symbol valid
//   req_data     [NREQ*SYM_W]  per-requester symbol, requester i at [i*SYM_W +: SYM_W]
//   req_last     [NREQ]        final symbol of the requester's stream
//   req_ready    [NREQ]        per-requester accept, one-hot or zero
//   det_data     [SYM_W]       symbol to the detector
//   det_valid                  det_data carries a live symbol
//   det_clear                  one-cycle detector clear on owner change
//   det_found                  registered detector match for last cycle's symbol
//   match_valid                one-cycle match event
//   match_id     [IDW]         owner of the matching symbol
//   match_cnt    [NREQ*8]      per-requester saturating match counters
//   grant_id     [IDW]         current owner, meaningful while busy
//   busy                       high in every state except IDLE

module seq_det_arbiter #(
    parameter int NREQ  = 4,
    parameter int SYM_W = 3,
    parameter int BURST = 4,
    parameter int TMO   = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*SYM_W-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [SYM_W-1:0]      det_data,
    output logic                  det_valid,
    output logic                  det_clear,
    input  logic                  det_found,
    output logic                  match_valid,
    output logic [IDW-1:0]        match_id,
    output logic [NREQ*8-1:0]     match_cnt,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int BCW = $clog2(BURST + 1);
    localparam int TCW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   grant_q;
    logic [IDW-1:0]   last_grant;
    logic [BCW-1:0]   burst_cnt;
    logic [TCW-1:0]   idle_cnt;
    logic             det_valid_q;
    logic [IDW-1:0]   det_owner_q;
    logic [7:0]       cnt_q [NREQ];

    logic             rr_found;
    logic [IDW-1:0]   rr_pick;
    logic             g_valid;
    logic             g_last;
    logic [SYM_W-1:0] g_data;
    logic             accept;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NREQ;
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = IDW'(idx);
            end
        end
    end

    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_data  = req_data[int'(grant_q)*SYM_W +: SYM_W];

    always_comb begin
        state_n   = state;
        req_ready = '0;
        det_valid = 1'b0;
        det_data  = '0;
        det_clear = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rr_found) begin
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                det_clear = 1'b1;
                state_n   = S_STREAM;
            end
            S_STREAM: begin
                req_ready = NREQ'(1) << grant_q;
                accept    = g_valid;
                det_valid = g_valid;
                det_data  = g_valid ? g_data : '0;
                if (accept) begin
                    // req_last only matters on an accepted symbol.
                    if (g_last || burst_cnt == BCW'(BURST - 1)) begin
                        state_n = S_DRAIN;
                    end
                end else if (idle_cnt == TCW'(TMO - 1)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= S_IDLE;
            grant_q     <= '0;
            last_grant  <= IDW'(NREQ - 1);
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            det_valid_q <= 1'b0;
            det_owner_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (rr_found) begin
                        grant_q <= rr_pick;
                    end
                end
                S_CLEAR: begin
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                end
                S_STREAM: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + BCW'(1);
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TCW'(1);
                    end
                end
                S_DRAIN: begin
                    last_grant <= grant_q;
                end
                default: begin
                end
            endcase
            // Tag each forwarded symbol with its owner so the registered
            // det_found of the next cycle is credited correctly.
            det_valid_q <= det_valid;
            det_owner_q <= grant_q;
            if (match_valid && cnt_q[det_owner_q] != 8'hFF) begin
                cnt_q[det_owner_q] <= cnt_q[det_owner_q] + 8'd1;
            end
        end
    end

    assign match_valid = det_found & det_valid_q;
    assign match_id    = det_owner_q;
    assign grant_id    = grant_q;

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            match_cnt[i*8 +: 8] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb/tb_seq_det_arbiter.sv - self-checking bench for seq_det_arbiter against a grant-schedule model

module tb_seq_det_arbiter;

    localparam int NREQ  = 4;
    localparam int SYM_W = 3;
    localparam int BURST = 4;
    localparam int TMO   = 8;
    localparam int IDW   = 2;
    localparam int MAXC  = 1200;
    localparam int MAXS  = 320;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*SYM_W-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic [SYM_W-1:0]      det_data;
    logic                  det_valid;
    logic                  det_clear;
    logic                  det_found = 1'b0;
    logic                  match_valid;
    logic [IDW-1:0]        match_id;
    logic [NREQ*8-1:0]     match_cnt;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    seq_det_arbiter #(.NREQ(NREQ), .SYM_W(SYM_W), .BURST(BURST), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .det_data(det_data),
        .det_valid(det_valid), .det_clear(det_clear), .det_found(det_found),
        .match_valid(match_valid), .match_id(match_id), .match_cnt(match_cnt),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Per-requester symbol streams.
    logic [SYM_W-1:0] s_data [NREQ][MAXS];
    bit               s_last [NREQ][MAXS];
    int               s_len  [NREQ];

    // Expected per-cycle behaviour from the grant schedule.
    bit               e_busy  [MAXC];
    bit               e_clear [MAXC];
    bit               e_acc   [MAXC];
    int               e_gid   [MAXC];
    logic [NREQ-1:0]  e_ready [MAXC];
    logic [SYM_W-1:0] e_data  [MAXC];
    bit               found   [MAXC];
    int               dptr    [MAXC][NREQ];
    int               sched_end;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_streams();
        for (int i = 0; i < NREQ; i++) begin
            s_len[i] = 0;
            for (int j = 0; j < MAXS; j++) begin
                s_data[i][j] = '0;
                s_last[i][j] = 1'b0;
            end
        end
        for (int c = 0; c < MAXC; c++) found[c] = 1'b0;
    endtask

    // Walk the streams grant by grant: each grant is IDLE, CLEAR, accepts
    // (until last or BURST, or TMO idle cycles if the stream runs dry), DRAIN.
    task automatic build_sched();
        int ptr [NREQ];
        int t, last, o, k, c, i;
        bit l;
        for (c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_clear[c] = 0; e_acc[c] = 0; e_gid[c] = 0;
            e_ready[c] = '0; e_data[c] = '0;
        end
        for (i = 0; i < NREQ; i++) ptr[i] = 0;
        t = 0;
        last = NREQ - 1;
        while (1) begin
            o = -1;
            for (k = 1; k <= NREQ; k++) begin
                i = (last + k) % NREQ;
                if (o < 0 && ptr[i] < s_len[i]) o = i;
            end
            if (o < 0) break;
            if (t + 3 + BURST + TMO >= MAXC) begin
                $fatal(1, "FAIL sched_overflow observed=%0d expected<%0d", t, MAXC);
            end
            dptr[t] = ptr;
            dptr[t+1] = ptr; e_busy[t+1] = 1; e_clear[t+1] = 1; e_gid[t+1] = o;
            c = t + 2;
            k = 0;
            while (1) begin
                dptr[c] = ptr; e_busy[c] = 1; e_gid[c] = o;
                e_ready[c] = NREQ'(1) << o; e_acc[c] = 1;
                e_data[c] = s_data[o][ptr[o]];
                l = s_last[o][ptr[o]];
                ptr[o]++; k++; c++;
                if (l || k == BURST) break;
                if (ptr[o] >= s_len[o]) begin
                    repeat (TMO) begin
                        dptr[c] = ptr; e_busy[c] = 1; e_gid[c] = o;
                        e_ready[c] = NREQ'(1) << o;
                        c++;
                    end
                    break;
                end
            end
            dptr[c] = ptr; e_busy[c] = 1; e_gid[c] = o;
            last = o;
            t = c + 1;
        end
        sched_end = t;
        for (c = t; c < MAXC; c++) dptr[c] = ptr;
    endtask

    task automatic drive(input int c);
        int p;
        for (int i = 0; i < NREQ; i++) begin
            p = dptr[c][i];
            if (p < s_len[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*SYM_W +: SYM_W] = s_data[i][p];
                req_last[i] = s_last[i][p];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*SYM_W +: SYM_W] = '0;
                req_last[i] = 1'b0;
            end
        end
        det_found = found[c];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " ready"}, 64'(req_ready), 64'd0);
        chk({tag, " det_valid"}, 64'(det_valid), 64'd0);
        chk({tag, " det_data"}, 64'(det_data), 64'd0);
        chk({tag, " det_clear"}, 64'(det_clear), 64'd0);
        chk({tag, " match_valid"}, 64'(match_valid), 64'd0);
        chk({tag, " match_cnt"}, 64'(match_cnt), 64'd0);
        chk({tag, " grant_id"}, 64'(grant_id), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; det_found = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
    endtask

    // Entered at #1 after a rising edge with reset asserted.
    task automatic run(input string name, input int ncyc, input int abort_at);
        int mc [NREQ];
        logic [NREQ*8-1:0] ev;
        for (int i = 0; i < NREQ; i++) mc[i] = 0;
        rst_n = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            drive(c);
            if (c == abort_at) begin
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check_zero({name, " abort"});
                return;
            end
            @(negedge clk);
            chk($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(e_busy[c]));
            if (e_busy[c]) chk($sformatf("%s c%0d grant_id", name, c), 64'(grant_id), 64'(e_gid[c]));
            chk($sformatf("%s c%0d ready", name, c), 64'(req_ready), 64'(e_ready[c]));
            chk($sformatf("%s c%0d det_clear", name, c), 64'(det_clear), 64'(e_clear[c]));
            chk($sformatf("%s c%0d det_valid", name, c), 64'(det_valid), 64'(e_acc[c]));
            chk($sformatf("%s c%0d det_data", name, c), 64'(det_data), 64'(e_acc[c] ? e_data[c] : '0));
            begin
                bit em;
                em = (c > 0) && found[c] && e_acc[c-1];
                chk($sformatf("%s c%0d match_valid", name, c), 64'(match_valid), 64'(em));
                if (em) chk($sformatf("%s c%0d match_id", name, c), 64'(match_id), 64'(e_gid[c-1]));
                for (int i = 0; i < NREQ; i++) ev[i*8 +: 8] = 8'(mc[i]);
                chk($sformatf("%s c%0d match_cnt", name, c), 64'(match_cnt), 64'(ev));
                if (em && mc[e_gid[c-1]] < 255) mc[e_gid[c-1]]++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state.
        clear_streams();
        do_reset();

        // Single stream 1,0,1,1 with last on the fourth; match reported after it.
        clear_streams();
        s_len[0] = 4;
        s_data[0][0] = 3'd1; s_data[0][1] = 3'd0; s_data[0][2] = 3'd1; s_data[0][3] = 3'd1;
        s_last[0][3] = 1'b1;
        found[6] = 1'b1;
        build_sched();
        do_reset();
        run("basic", 12, -1);
        chk("basic cnt0", 64'(match_cnt[7:0]), 64'd1);

        // Two continuous requesters alternate in BURST-sized grants.
        clear_streams();
        s_len[1] = 8; s_len[2] = 8;
        for (int j = 0; j < 8; j++) begin
            s_data[1][j] = 3'($urandom_range(0, 7));
            s_data[2][j] = 3'($urandom_range(0, 7));
            found[$urandom_range(0, 40)] = 1'b1;
        end
        s_last[1][7] = 1'b1; s_last[2][7] = 1'b1;
        build_sched();
        do_reset();
        run("alt", sched_end + 4, -1);

        // Owner stalls after one symbol: timeout, then the waiting requester.
        clear_streams();
        s_len[0] = 1; s_data[0][0] = 3'd5;
        s_len[1] = 3; s_data[1][0] = 3'd2; s_data[1][1] = 3'd7; s_data[1][2] = 3'd4;
        s_last[1][2] = 1'b1;
        found[3] = 1'b1;
        build_sched();
        do_reset();
        run("tmo", sched_end + 4, -1);

        // det_found stuck high: matches only after live symbols, counter saturates.
        clear_streams();
        s_len[0] = 304;
        for (int j = 0; j < 304; j++) s_data[0][j] = 3'($urandom_range(0, 7));
        s_last[0][303] = 1'b1;
        for (int c = 0; c < MAXC; c++) found[c] = 1'b1;
        build_sched();
        do_reset();
        run("sat", sched_end + 2, -1);
        chk("sat cnt0", 64'(match_cnt[7:0]), 64'd255);

        // Reset during the third symbol, then a fresh grant to requester 0.
        clear_streams();
        s_len[0] = 8; s_len[1] = 4;
        for (int j = 0; j < 8; j++) s_data[0][j] = 3'($urandom_range(0, 7));
        for (int j = 0; j < 4; j++) s_data[1][j] = 3'($urandom_range(0, 7));
        s_last[0][7] = 1'b1; s_last[1][3] = 1'b1;
        for (int c = 0; c < MAXC; c++) found[c] = 1'b1;
        build_sched();
        do_reset();
        run("midrst", 10, 4);
        run("postrst", sched_end + 2, -1);

        // Randomised streams with random lasts, dry-ups and detector hits.
        for (int r = 0; r < 4; r++) begin
            clear_streams();
            for (int i = 0; i < NREQ; i++) begin
                s_len[i] = $urandom_range(0, 16);
                for (int j = 0; j < s_len[i]; j++) begin
                    s_data[i][j] = 3'($urandom_range(0, 7));
                    s_last[i][j] = ($urandom_range(0, 3) == 0);
                end
                if (s_len[i] > 0 && $urandom_range(0, 1) == 1) s_last[i][s_len[i]-1] = 1'b1;
            end
            for (int c = 0; c < MAXC; c++) found[c] = ($urandom_range(0, 1) == 1);
            build_sched();
            do_reset();
            run($sformatf("rnd%0d", r), sched_end + 3, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
